if_btb: RTL and testbench
=========================

# if_btb

Instruction-fetch stage with a parametrised, direct-mapped branch target buffer (BTB) and 2-bit saturating-counter direction prediction. It holds the PC, drives the instruction-memory address and returns the fetched word, the predicted next PC and the link address to the IF/ID pipeline register. The EX stage resolves branches and jumps and feeds back redirect and training information. Two wrapping performance counters support SDU debugging.

## Interface
- `ENTRIES`, 16: BTB entry count; power of two, ≥2; `IDX = log2(ENTRIES)`.
- `IMEM_AW`, 10: instruction-memory word-address width.
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `CNT_INIT`, 2'b01: counter value after reset (weakly not-taken).

- `clk` in 1: clock; all state updates on the rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `stall` in 1: hold PC (hazard unit).
- `redirect` in 1: EX detected a mispredict; load `redirect_pc`.
- `redirect_pc` in 32: correct next PC.
- `upd_en` in 1: EX resolved a branch/jump this cycle; train the BTB.
- `upd_pc` in 32: PC of the resolved instruction.
- `upd_taken` in 1: actual direction.
- `upd_target` in 32: actual target, meaningful when taken.
- `imem_addr` out IMEM_AW: `pc[IMEM_AW+1:2]`.
- `imem_data` in 32: combinational instruction-memory read data.
- `ir` out 32: equals `imem_data`.
- `pc` out 32: current PC.
- `ra` out 32: `pc + 4`.
- `pred_taken` out 1: BTB hit with counter ≥ 2.
- `pred_pc` out 32: predicted next PC, carried down the pipeline for the EX compare.
- `npc` out 32: value the PC loads at the next edge (debug).
- `hit_cnt` out 32: number of cycles where `pred_taken` was high and the PC advanced.
- `redir_cnt` out 32: number of accepted redirects.

## Operation
- Index: `pc[IDX+1:2]`. Tag: `pc[31:IDX+2]`.
- Each entry holds `valid`, `tag`, `target[31:0]` and `cnt[1:0]`.
- Lookup is combinational on the current `pc`.
  - `hit = valid && tag match`.
  - `pred_taken = hit && cnt[1]`.
  - `pred_pc = pred_taken ? target : pc + 4`.
- `npc` priority:
  1. `redirect` → `{redirect_pc[31:1], 1'b0}`. Redirect overrides `stall`.
  2. else `stall` → `pc`.
  3. else `pred_pc`.
- The PC register always loads `npc`.
- Training (rising edge, when `upd_en`), at index/tag of `upd_pc`:
  - Hit, taken: `cnt` saturating increment (max 3); `target ← upd_target`.
  - Hit, not taken: `cnt` saturating decrement (min 0); `target` unchanged.
  - Miss, taken: allocate/replace the entry: `valid=1`, new tag, `target=upd_target`, `cnt=2'b10`.
  - Miss, not taken: no change.
- Training is independent of `stall` and `redirect`.
- Same-cycle lookup and training of the same entry: the lookup uses the pre-edge contents.
- `hit_cnt` increments when `pred_taken && !stall && !redirect`.
- `redir_cnt` increments when `redirect`.
- Both counters wrap from 2^32−1 to 0.

## Timing
- Reset values:
  - `pc = RESET_PC`.
  - All `valid = 0`; all `cnt = CNT_INIT`; tags and targets = 0.
  - `hit_cnt = redir_cnt = 0`.
  - After reset: `pred_taken = 0`, `pred_pc = RESET_PC + 4`, `ra = RESET_PC + 4`.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. The first fetch after release is from `RESET_PC`.
- `ir`, `ra`, `pred_taken`, `pred_pc` and `npc` are combinational from `pc`, BTB state, `imem_data` and the control inputs, with zero latency. The pipeline register downstream samples them.
- Prediction-to-PC latency is one edge.
- A redirect takes effect at the next edge (mispredict penalty is set by the pipeline depth to EX).
- A trained entry is visible to lookup on the cycle after the `upd_en` edge.
- Aliasing: two PCs with the same index evict each other. The tag compare prevents false hits.

## Test plan
- Reset and sequential fetch: hold `rstn=0` then release, no other inputs → `pc` steps 0, 4, 8, 12; `pred_taken=0` throughout; `imem_addr` steps 0, 1, 2, 3.
- Allocate and predict: `upd_en`, `upd_pc=0x10`, `upd_taken=1`, `upd_target=0x40`; then fetch reaches 0x10 → `pred_taken=1`, `pred_pc=0x40`, and the next `pc=0x40`; `hit_cnt` increments by 1.
- Counter saturation: 3 more taken updates at 0x10 (cnt 3), then 1 not-taken (cnt 2) → still predicts 0x40; a 2nd not-taken (cnt 1) → `pred_pc=0x14`.
- Redirect over stall: `stall=1`, `redirect=1`, `redirect_pc=0x101` → next `pc=0x100`; `redir_cnt=1`. With `stall=1` alone, `pc` holds for 3 cycles.
- Alias eviction (ENTRIES=16): train 0x10→0x40, then train 0x50→0x80 taken (same index) → at 0x10 `pred_taken=0`; at 0x50 `pred_pc=0x80`.
- Asynchronous reset mid-run: assert `rstn=0` between clock edges → `pc=RESET_PC` and the BTB is empty before the next edge; `hit_cnt` and `redir_cnt` read 0.

Source files
------------

// File: rtl/if_btb.sv
// Instruction-fetch stage: PC register, direct-mapped BTB with 2-bit direction
// counters, EX-driven training/redirect, and wrapping debug counters.
module if_btb #(
  parameter int          ENTRIES  = 16,
  parameter int          IMEM_AW  = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               upd_en,
  input  logic [31:0]        upd_pc,
  input  logic               upd_taken,
  input  logic [31:0]        upd_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        ir,
  output logic [31:0]        pc,
  output logic [31:0]        ra,
  output logic               pred_taken,
  output logic [31:0]        pred_pc,
  output logic [31:0]        npc,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        redir_cnt
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic              btb_vld [ENTRIES];
  logic [TAG_W-1:0]  btb_tag [ENTRIES];
  logic [31:0]       btb_tgt [ENTRIES];
  logic [1:0]        btb_cnt [ENTRIES];

  logic [31:0]       pc_p0;
  logic [IDX-1:0]    lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;
  logic [IDX-1:0]    up_idx;
  logic [TAG_W-1:0]  up_tag;
  logic              up_hit;
  logic              unused_bits;

  // Stage p0: combinational lookup and next-PC selection on the current PC
  assign lk_idx     = pc_p0[IDX+1:2];
  assign lk_tag     = pc_p0[31:IDX+2];
  assign lk_hit     = btb_vld[lk_idx] && (btb_tag[lk_idx] == lk_tag);
  assign pred_taken = lk_hit && btb_cnt[lk_idx][1];
  assign ra         = pc_p0 + 32'd4;
  assign pred_pc    = pred_taken ? btb_tgt[lk_idx] : ra;
  assign pc         = pc_p0;
  assign imem_addr  = pc_p0[IMEM_AW+1:2];
  assign ir         = imem_data;

  always_comb begin
    npc = pred_pc;
    if (redirect)   npc = {redirect_pc[31:1], 1'b0};
    else if (stall) npc = pc_p0;
  end

  assign up_idx      = upd_pc[IDX+1:2];
  assign up_tag      = upd_pc[31:IDX+2];
  assign up_hit      = btb_vld[up_idx] && (btb_tag[up_idx] == up_tag);
  assign unused_bits = ^{upd_pc[1:0], redirect_pc[0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_p0     <= RESET_PC;
      hit_cnt   <= '0;
      redir_cnt <= '0;
    end else begin
      pc_p0 <= npc;
      if (pred_taken && !stall && !redirect) hit_cnt <= hit_cnt + 32'd1;
      if (redirect)                          redir_cnt <= redir_cnt + 32'd1;
    end
  end

  // Training writes land after the edge, so same-cycle lookups see old contents
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_vld[i] <= 1'b0;
        btb_tag[i] <= '0;
        btb_tgt[i] <= '0;
        btb_cnt[i] <= CNT_INIT;
      end
    end else if (upd_en) begin
      if (up_hit) begin
        if (upd_taken) begin
          btb_cnt[up_idx] <= sat_inc(btb_cnt[up_idx]);
          btb_tgt[up_idx] <= upd_target;
        end else begin
          btb_cnt[up_idx] <= sat_dec(btb_cnt[up_idx]);
        end
      end else if (upd_taken) begin
        btb_vld[up_idx] <= 1'b1;
        btb_tag[up_idx] <= up_tag;
        btb_tgt[up_idx] <= upd_target;
        btb_cnt[up_idx] <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_if_btb.sv
// Scoreboard bench for if_btb: directed stimulus queues expected values, a
// negedge monitor pops and compares them against the live outputs.
module tb_if_btb;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall, redirect, upd_en, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target, imem_data;
  logic [9:0]  imem_addr;
  logic [31:0] ir, pc, ra, pred_pc, npc, hit_cnt, redir_cnt;
  logic        pred_taken;

  if_btb #(.ENTRIES(16), .IMEM_AW(10), .RESET_PC(32'h0), .CNT_INIT(2'b01)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .imem_addr(imem_addr),
    .imem_data(imem_data), .ir(ir), .pc(pc), .ra(ra), .pred_taken(pred_taken),
    .pred_pc(pred_pc), .npc(npc), .hit_cnt(hit_cnt), .redir_cnt(redir_cnt)
  );

  always #5 clk = ~clk;

  localparam int S_PC = 0, S_PT = 1, S_PP = 2, S_IA = 3, S_HC = 4,
                 S_RC = 5, S_NPC = 6, S_RA = 7, S_IR = 8;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_PC:    return pc;
      S_PT:    return {31'd0, pred_taken};
      S_PP:    return pred_pc;
      S_IA:    return {22'd0, imem_addr};
      S_HC:    return hit_cnt;
      S_RC:    return redir_cnt;
      S_NPC:   return npc;
      S_RA:    return ra;
      default: return ir;
    endcase
  endfunction

  task automatic ex(input string name, input int sel, input logic [31:0] v);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = v;
    q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic en, input logic [31:0] p, input logic tk,
                         input logic [31:0] tg);
    upd_en = en; upd_pc = p; upd_taken = tk; upd_target = tg;
  endtask

  // Monitor: outputs are continuously presented; compare everything queued this cycle
  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [31:0] a;
      c = q.pop_front();
      a = actual(c.sel);
      n_tests++;
      if (a !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, a, c.exp);
      end
    end
  end

  initial begin
    rstn = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    imem_data = 32'h1234_5678;

    step();
    ex("rst_pc", S_PC, 32'h0);      ex("rst_pt", S_PT, 32'h0);
    ex("rst_pp", S_PP, 32'h4);      ex("rst_ra", S_RA, 32'h4);
    ex("rst_hc", S_HC, 32'h0);      ex("rst_rc", S_RC, 32'h0);
    ex("rst_ia", S_IA, 32'h0);      ex("ir_pass", S_IR, 32'h1234_5678);
    step();

    // Sequential fetch from RESET_PC
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ex($sformatf("seq_pc%0d", i), S_PC, 32'(4 * i));
      ex($sformatf("seq_ia%0d", i), S_IA, 32'(i));
      ex($sformatf("seq_pt%0d", i), S_PT, 32'h0);
      if (i == 3) set_upd(1'b1, 32'h10, 1'b1, 32'h40);
      step();
    end

    // Entry trained at the edge that brought pc to 0x10 is visible now
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    imem_data = 32'hCAFE_F00D;
    ex("alloc_pc", S_PC, 32'h10);   ex("alloc_pt", S_PT, 32'h1);
    ex("alloc_pp", S_PP, 32'h40);   ex("alloc_npc", S_NPC, 32'h40);
    ex("alloc_ir", S_IR, 32'hCAFE_F00D);
    step();
    ex("jump_pc", S_PC, 32'h40);    ex("hit_cnt1", S_HC, 32'h1);

    // Hold at 0x40 while training: 3 taken then 1 not-taken -> cnt 2
    stall = 1'b1;
    set_upd(1'b1, 32'h10, 1'b1, 32'h40);
    step(); step(); step();
    ex("stall_pc", S_PC, 32'h40);
    set_upd(1'b1, 32'h10, 1'b0, 32'h0);
    step();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h10;
    ex("redir_npc", S_NPC, 32'h10);
    step();
    redirect = 1'b0;
    ex("sat_pc", S_PC, 32'h10);     ex("sat_pt", S_PT, 32'h1);
    ex("sat_pp", S_PP, 32'h40);     ex("redir_cnt1", S_RC, 32'h1);
    stall = 1'b1;
    set_upd(1'b1, 32'h10, 1'b0, 32'h0);
    ex("stall_npc", S_NPC, 32'h10);
    step();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    ex("weak_pt", S_PT, 32'h0);     ex("weak_pp", S_PP, 32'h14);
    ex("stall_hc", S_HC, 32'h1);

    // Redirect overrides stall; odd target LSB is cleared
    redirect = 1'b1; redirect_pc = 32'h101;
    ex("rvs_npc", S_NPC, 32'h100);
    step();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex($sformatf("hold_pc%0d", i), S_PC, 32'h100);
      step();
    end
    ex("redir_cnt2", S_RC, 32'h2);

    // Alias: 0x10 and 0x50 share index 4
    set_upd(1'b1, 32'h10, 1'b1, 32'h40);
    step();
    set_upd(1'b1, 32'h50, 1'b1, 32'h80);
    step();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h10;
    step();
    ex("alias_pc", S_PC, 32'h10);   ex("alias_pt", S_PT, 32'h0);
    ex("alias_pp", S_PP, 32'h14);
    redirect_pc = 32'h50;
    ex("alias_npc", S_NPC, 32'h50);
    step();
    redirect = 1'b0;
    ex("evict_pt", S_PT, 32'h1);    ex("evict_pp", S_PP, 32'h80);
    step();
    ex("evict_pc", S_PC, 32'h80);   ex("hit_cnt2", S_HC, 32'h2);
    ex("redir_cnt4", S_RC, 32'h4);
    step();

    // Asynchronous reset between edges
    #2 rstn = 1'b0;
    #1;
    ex("arst_pc", S_PC, 32'h0);     ex("arst_hc", S_HC, 32'h0);
    ex("arst_rc", S_RC, 32'h0);     ex("arst_pp", S_PP, 32'h4);
    step();
    ex("arst_hold", S_PC, 32'h0);
    step();
    rstn = 1'b1; redirect = 1'b1; redirect_pc = 32'h50;
    step();
    redirect = 1'b0;
    ex("empty_pc", S_PC, 32'h50);   ex("empty_pt", S_PT, 32'h0);
    ex("empty_pp", S_PP, 32'h54);   ex("empty_rc", S_RC, 32'h1);
    step();
    step();

    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d checks left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
